// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep checker: FSM encoding and
// reference masks for the guide's example gate functions.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    // Bit i is the expected output for input vector index i = {x,y,z}.
    localparam logic [7:0] MASK_OR_XZ     = 8'hFA;  // s = x | z
    localparam logic [7:0] MASK_NOTY_NOTZ = 8'h10;  // s = ~y & ~z & x

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable down-counter with a zero flag; sets how long each stimulus
// vector dwells before its response is sampled.
module tt_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; decrement stops at zero so the flag stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives every input combination of a small combinational function in
// ascending order, samples its output after a settle dwell and scores it
// against an expected truth-table mask.
//
// Handshake: start is a single-cycle request accepted only when no sweep is
// running (IDLE or DONE); abort is accepted only while busy and then takes
// priority over start. Results are valid while done is high.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int                    N_IN        = 3,
    parameter logic [(1<<N_IN)-1:0]  EXPECT_MASK = MASK_OR_XZ,
    parameter int                    SETTLE      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_s,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx,
    output logic [1:0]      dbg_state
);

    localparam int              CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]   SET_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    tt_state_e       r_state;
    tt_state_e       w_state_nxt;
    logic [N_IN-1:0] r_vec;
    logic [N_IN:0]   r_err;
    logic            r_ff_valid;
    logic [N_IN-1:0] r_ff_idx;

    logic w_running;
    logic w_start_go;
    logic w_sample_fire;
    logic w_mismatch;
    logic w_last;
    logic w_settled;

    assign w_running     = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
    assign w_start_go    = start && !w_running;
    // An abort landing on the SAMPLE cycle discards that vector's result.
    assign w_sample_fire = (r_state == ST_SAMPLE) && !abort;
    assign w_mismatch    = (dut_s != EXPECT_MASK[r_vec]);
    assign w_last        = (r_vec == VEC_LAST);

    tt_settle_cnt #(.W(CW)) u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start_go || (w_sample_fire && !w_last)),
        .i_load_val (SET_LOAD),
        .i_dec      (r_state == ST_APPLY),
        .o_zero     (w_settled)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: abort beats everything while a sweep is running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_APPLY;
            ST_APPLY: begin
                if (abort)          w_state_nxt = ST_IDLE;
                else if (w_settled) w_state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
                else             w_state_nxt = ST_APPLY;
            end
            ST_DONE:   if (start) w_state_nxt = ST_APPLY;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Stimulus vector and result capture; a new start clears all results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= '0;
            r_err      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
        end else if (w_start_go) begin
            r_vec      <= '0;
            r_err      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
        end else if (w_sample_fire) begin
            if (w_mismatch) begin
                r_err <= r_err + (N_IN+1)'(1);
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_idx   <= r_vec;
                end
            end
            if (!w_last) begin
                r_vec <= r_vec + N_IN'(1);
            end
        end
    end

    assign vec_out          = r_vec;
    assign busy             = w_running;
    assign done             = (r_state == ST_DONE);
    assign pass             = done && (r_err == '0);
    assign err_count        = r_err;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_idx   = r_ff_idx;
    assign dbg_state        = r_state;

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Sequential stimulus and response stage for the combinational gate exercises in the logic guides. On a start pulse it drives every input combination, x y z, onto the function under test in ascending binary order. It samples that function's single output after a settle interval and compares each sample against an expected truth-table mask. It reports the error count, the first failing vector and a pass/fail verdict, replacing the open-loop $monitor benches with a self-checking sweep.

Parameters:
N_IN, 3, number of function inputs (1..6); the sweep covers 2^N_IN vectors.
EXPECT_MASK, 8'hFA, expected output per vector; bit i is the expected s for vector index i. The default encodes s = x OR z with index {x,y,z}. The width is 2^N_IN.
SETTLE, 1, cycles each vector is held before sampling (at least 1).

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep
abort  input  1  synchronous cancel of a running sweep
vec_out  output  N_IN  stimulus to the function under test; MSB = x, LSB = z
dut_s  input  1  output of the function under test
busy  output  1  sweep in progress
done  output  1  sticky; sweep completed, results valid
pass  output  1  done AND err_count == 0
err_count  output  N_IN+1  number of mismatching vectors
first_fail_valid  output  1  at least one mismatch recorded
first_fail_idx  output  N_IN  lowest vector index that mismatched

Behaviour:
- Reset: single clock, reset asynchronous and active-low. rst_n low forces all outputs to 0 immediately, independent of clk, and puts the FSM in IDLE.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE: start=1 moves to APPLY and loads vec_out=0. It also clears err_count, first_fail_* and done, and sets busy=1.
- APPLY: vec_out is held stable. The state lasts SETTLE cycles, counted by the settle counter, then moves to SAMPLE.
- SAMPLE: a one-cycle state.
  - Compares dut_s with EXPECT_MASK[vec_out].
  - On mismatch, err_count increments. If first_fail_valid=0, it also captures first_fail_idx=vec_out and sets first_fail_valid=1.
  - If vec_out == 2^N_IN-1, the next state is DONE. Otherwise vec_out increments and the next state is APPLY.
- Timing: each vector occupies SETTLE+1 cycles. Take edge t0 as the edge that samples start. Vector i is driven from edge t0+i*(SETTLE+1) and its dut_s is sampled at edge t0+(i+1)*(SETTLE+1). At edge t0+2^N_IN*(SETTLE+1), busy=0 and done=1. Defaults give 16 cycles.
- DONE: results and vec_out are held. start=1 restarts exactly as from IDLE, clearing results on the same edge.
- start while busy is ignored.
- abort while busy: next edge goes to IDLE with busy=0 and done=0. err_count and first_fail_* hold their partial values.
- abort outside busy is ignored. abort and start in the same cycle: abort wins if busy; otherwise start wins.
- err_count never wraps; its maximum is 2^N_IN.
- vec_out wraps only by restart; there is no increment past 2^N_IN-1.
- pass is combinational from done and err_count. It is 0 whenever done=0.

Decomposition:
- Shared package tt_pkg holds:
  - FSM state encoding constants ST_IDLE=2'd0, ST_APPLY=2'd1, ST_SAMPLE=2'd2, ST_DONE=2'd3.
  - Default mask constants for the guide functions: MASK_OR_XZ=8'hFA and MASK_NOTY_NOTZ=8'h10, for s = ~y & ~z & x.
- One sub-module, tt_settle_cnt: a loadable down-counter of width clog2(SETTLE+1) with a zero flag. The checker instantiates it for the APPLY dwell.

Test Plan:
- Reset: hold rst_n=0 mid-cycle → all outputs 0 without a clock edge. Release and idle for 5 cycles → busy=0, done=0.
- Correct DUT: dut_s = vec_out[2] | vec_out[0], pulse start → vec_out steps 0..7 every 2 cycles. busy=1 for 16 cycles, then done=1, err_count=0, pass=1, first_fail_valid=0.
- Stuck-at-0 DUT: dut_s=0 → after 16 cycles err_count=6, first_fail_idx=1, first_fail_valid=1, pass=0.
- Inverted DUT (NOR): dut_s = ~(x|z) → err_count=8, first_fail_idx=0, pass=0.
- Handshake:
  - start pulsed again at cycle 4 → ignored, sweep completes at cycle 16.
  - New sweep with abort at cycle 5 → busy=0 and done=0 at the next edge.
  - start from DONE with a correct DUT → results cleared the same edge, pass=1 after 16 cycles.
- Reset mid-sweep: drop rst_n at cycle 7 → vec_out=0, busy=0, err_count=0 immediately. After release, start → a full clean sweep of 16 cycles.
